// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the transmit-path arbiter and its round-robin picker.
package tx_arbiter_pkg;

  localparam int         ID_W         = 3;
  localparam logic [7:0] HDR_BASE_DEF = 8'hA0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEND = 2'd2
  } state_e;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_pick
  import tx_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] id,
  output logic            found
);

  int           idx;
  logic [N-1:0] req_sh;

  always_comb begin
    id     = '0;
    found  = 1'b0;
    idx    = 0;
    req_sh = '0;
    for (int k = 1; k <= N; k++) begin
      idx    = (int'(ptr) + k) % N;
      req_sh = req >> idx;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Packet-level round-robin arbiter feeding one UART transmit FIFO, with a
// source header per packet and an idle-timeout abort.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int         N        = 4,
  parameter logic [7:0] HDR_BASE = HDR_BASE_DEF,
  parameter int         TIMEOUT  = 1023,
  parameter int         TW       = 10
) (
  input  logic             clk_TxArb,
  input  logic             reset_TxArb,
  input  logic [N-1:0]     req_TxArb,
  input  logic [8*N-1:0]   data_TxArb,
  input  logic [N-1:0]     last_TxArb,
  output logic [N-1:0]     ack_TxArb,
  input  logic             tx_full_TxArb,
  output logic             wr_uart_TxArb,
  output logic [7:0]       w_data_TxArb,
  output logic [ID_W-1:0]  grant_TxArb,
  output logic             busy_TxArb,
  output logic             abort_TxArb
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            abort_q, abort_d;

  logic [ID_W-1:0] pick_id;
  logic            pick_found;
  logic [N-1:0]    sel, req_sh, last_sh;
  logic [8*N-1:0]  data_sh;
  logic            req_g, last_g;
  logic [7:0]      data_g;

  rr_pick #(.N(N)) u_pick (
    .req   (req_TxArb),
    .ptr   (rr_ptr_q),
    .id    (pick_id),
    .found (pick_found)
  );

  // Granted requester's lane, selected by shifting rather than indexing.
  always_comb begin
    sel     = {{(N-1){1'b0}}, 1'b1} << grant_q;
    req_sh  = req_TxArb >> grant_q;
    last_sh = last_TxArb >> grant_q;
    data_sh = data_TxArb >> {grant_q, 3'b000};
    req_g   = req_sh[0];
    last_g  = last_sh[0];
    data_g  = data_sh[7:0];
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    abort_d       = 1'b0;
    wr_uart_TxArb = 1'b0;
    w_data_TxArb  = 8'h00;
    ack_TxArb     = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_id;
          cnt_d   = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (!tx_full_TxArb) begin
          wr_uart_TxArb = 1'b1;
          w_data_TxArb  = HDR_BASE | {{(8-ID_W){1'b0}}, grant_q};
          state_d       = SEND;
        end
      end
      SEND: begin
        // A held byte under back-pressure is not a stall; only missing valid counts.
        if (req_g) begin
          cnt_d = '0;
          if (!tx_full_TxArb) begin
            wr_uart_TxArb = 1'b1;
            w_data_TxArb  = data_g;
            ack_TxArb     = sel;
            if (last_g) begin
              rr_ptr_d = grant_q;
              state_d  = IDLE;
            end
          end
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          abort_d  = 1'b1;
          rr_ptr_d = grant_q;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A packet dropped by reset must not leak a byte in the reset cycle.
    if (reset_TxArb) begin
      wr_uart_TxArb = 1'b0;
      w_data_TxArb  = 8'h00;
      ack_TxArb     = '0;
    end
  end

  always_ff @(posedge clk_TxArb) begin
    if (reset_TxArb) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= ID_W'(N - 1);
      cnt_q    <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
    end
  end

  assign grant_TxArb = grant_q;
  assign busy_TxArb  = (state_q != IDLE);
  assign abort_TxArb = abort_q;

endmodule
